// File: rtl/seg_pkg.sv
// seg_pkg: shared state/source encodings and defaults for the seven-segment display arbiter.
// Rev 1.0
`default_nettype none

package seg_pkg;

  typedef enum logic [1:0] {
    S_LIVE = 2'd0,
    S_EDIT = 2'd1,
    S_MSG  = 2'd2
  } state_t;

  localparam logic [1:0]  SRC_LIVE     = 2'd0;
  localparam logic [1:0]  SRC_EDIT     = 2'd1;
  localparam logic [1:0]  SRC_MSG      = 2'd2;

  localparam logic [19:0] DISP_MAX_DEF = 20'd999_999;
  localparam logic [15:0] TICK_MAX_DEF = 16'd49_999;

  function automatic logic [1:0] src_of(input state_t s);
    case (s)
      S_EDIT:  return SRC_EDIT;
      S_MSG:   return SRC_MSG;
      default: return SRC_LIVE;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/ms_tick_gen.sv
// ms_tick_gen: 1 ms prescaler with synchronous clear; tick is high for one clk at TICK_MAX.
// Rev 1.0
`default_nettype none

module ms_tick_gen
  import seg_pkg::*;
#(
  parameter logic [15:0] TICK_MAX = TICK_MAX_DEF
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  output logic tick
);

  logic [15:0] cnt;

  assign tick = (cnt == TICK_MAX);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/seg_disp_arbiter.sv
// seg_disp_arbiter: priority scheduler (msg > edit > live) feeding the 6-digit seven-segment driver.
// Rev 1.0
`default_nettype none

module seg_disp_arbiter
  import seg_pkg::*;
#(
  parameter logic [15:0] TICK_MAX = TICK_MAX_DEF,
  parameter logic [15:0] HOLD_MS  = 16'd2000,
  parameter logic [9:0]  BLINK_MS = 10'd250,
  parameter logic [19:0] DISP_MAX = DISP_MAX_DEF
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [19:0] live_data,
  input  logic [5:0]  live_point,
  input  logic        live_sign,
  input  logic        edit_active,
  input  logic [19:0] edit_data,
  input  logic [5:0]  edit_point,
  input  logic        edit_sign,
  input  logic        edit_blink,
  input  logic        msg_req,
  input  logic [19:0] msg_data,
  input  logic [5:0]  msg_point,
  input  logic        msg_sign,
  input  logic        disp_off,
  output logic [19:0] data,
  output logic [5:0]  point,
  output logic        sign,
  output logic        seg_en,
  output logic [1:0]  src,
  output logic        msg_busy,
  output logic        ovf
);

  state_t      state, nstate;
  logic [19:0] msg_data_q;
  logic [5:0]  msg_point_q;
  logic        msg_sign_q;
  logic [15:0] hold_cnt;
  logic [9:0]  blink_cnt, blink_cnt_n;
  logic        phase_off, phase_off_n;
  logic        hold_tick, blink_tick, expire;
  logic [19:0] sel_data;
  logic [5:0]  sel_point;
  logic        sel_sign;

  // Hold prescaler restarts on every accepted request so expiry is edge-exact.
  ms_tick_gen #(.TICK_MAX(TICK_MAX)) u_hold_tick (
    .clk  (clk),
    .rstn (rstn),
    .clr  (msg_req),
    .tick (hold_tick)
  );

  ms_tick_gen #(.TICK_MAX(TICK_MAX)) u_blink_tick (
    .clk  (clk),
    .rstn (rstn),
    .clr  (1'b0),
    .tick (blink_tick)
  );

  assign expire = (state == S_MSG) && hold_tick && (hold_cnt == HOLD_MS - 16'd1);

  always_comb begin
    nstate = state;
    if (msg_req) begin
      nstate = S_MSG;
    end else begin
      case (state)
        S_LIVE, S_EDIT: nstate = edit_active ? S_EDIT : S_LIVE;
        S_MSG:          if (expire) nstate = edit_active ? S_EDIT : S_LIVE;
        default:        nstate = S_LIVE;
      endcase
    end
  end

  always_comb begin
    blink_cnt_n = blink_cnt;
    phase_off_n = phase_off;
    if (nstate == S_EDIT && state != S_EDIT) begin
      blink_cnt_n = '0;
      phase_off_n = 1'b0;
    end else if (blink_tick) begin
      if (blink_cnt == BLINK_MS - 10'd1) begin
        blink_cnt_n = '0;
        phase_off_n = !phase_off;
      end else begin
        blink_cnt_n = blink_cnt + 10'd1;
      end
    end
  end

  // A message accepted this edge is shown straight from the inputs, since the latch loads on the same edge.
  always_comb begin
    sel_data  = live_data;
    sel_point = live_point;
    sel_sign  = live_sign;
    case (nstate)
      S_EDIT: begin
        sel_data  = edit_data;
        sel_point = edit_point;
        sel_sign  = edit_sign;
      end
      S_MSG: begin
        sel_data  = msg_req ? msg_data  : msg_data_q;
        sel_point = msg_req ? msg_point : msg_point_q;
        sel_sign  = msg_req ? msg_sign  : msg_sign_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= S_LIVE;
      msg_data_q  <= '0;
      msg_point_q <= '0;
      msg_sign_q  <= 1'b0;
      hold_cnt    <= '0;
      blink_cnt   <= '0;
      phase_off   <= 1'b0;
      data        <= '0;
      point       <= '0;
      sign        <= 1'b0;
      seg_en      <= 1'b0;
      src         <= SRC_LIVE;
      msg_busy    <= 1'b0;
      ovf         <= 1'b0;
    end else begin
      state     <= nstate;
      blink_cnt <= blink_cnt_n;
      phase_off <= phase_off_n;

      if (msg_req) begin
        msg_data_q  <= msg_data;
        msg_point_q <= msg_point;
        msg_sign_q  <= msg_sign;
        hold_cnt    <= '0;
      end else if (state == S_MSG && hold_tick) begin
        hold_cnt <= hold_cnt + 16'd1;
      end

      data     <= (sel_data > DISP_MAX) ? DISP_MAX : sel_data;
      ovf      <= (sel_data > DISP_MAX);
      point    <= sel_point;
      sign     <= sel_sign;
      seg_en   <= !disp_off && !(nstate == S_EDIT && edit_blink && phase_off_n);
      src      <= src_of(nstate);
      msg_busy <= (nstate == S_MSG);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seg_disp_arbiter.sv
// tb_seg_disp_arbiter: directed plus randomized checks of seg_disp_arbiter against a cycle-level reference model.
// Rev 1.0
`default_nettype none
`timescale 1ns/1ps

module tb_seg_disp_arbiter;

  localparam int HOLD_CLK    = 30;  // HOLD_MS(3) * (TICK_MAX(9)+1)
  localparam int TICK_CLK    = 10;
  localparam int BLINK_TICKS = 2;
  localparam logic [19:0] DMAX = 20'd999_999;

  logic        clk, rstn;
  logic [19:0] live_data, edit_data, msg_data;
  logic [5:0]  live_point, edit_point, msg_point;
  logic        live_sign, edit_active, edit_sign, edit_blink;
  logic        msg_req, msg_sign, disp_off;
  logic [19:0] data;
  logic [5:0]  point;
  logic        sign, seg_en, msg_busy, ovf;
  logic [1:0]  src;

  int checks = 0;
  int failures = 0;

  // Reference model: mode 0 live / 1 edit / 2 msg, hold counted in whole clk cycles.
  int          mode, left, cyc, bcnt;
  bit          off;
  logic [19:0] m_data;
  logic [5:0]  m_point;
  logic        m_sign;
  logic [19:0] e_data;
  logic [5:0]  e_point;
  logic        e_sign, e_seg_en, e_busy, e_ovf;
  logic [1:0]  e_src;

  seg_disp_arbiter #(
    .TICK_MAX(16'd9), .HOLD_MS(16'd3), .BLINK_MS(10'd2), .DISP_MAX(DMAX)
  ) dut (
    .clk(clk), .rstn(rstn),
    .live_data(live_data), .live_point(live_point), .live_sign(live_sign),
    .edit_active(edit_active), .edit_data(edit_data), .edit_point(edit_point),
    .edit_sign(edit_sign), .edit_blink(edit_blink),
    .msg_req(msg_req), .msg_data(msg_data), .msg_point(msg_point), .msg_sign(msg_sign),
    .disp_off(disp_off),
    .data(data), .point(point), .sign(sign), .seg_en(seg_en),
    .src(src), .msg_busy(msg_busy), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    mode = 0; left = 0; cyc = 0; bcnt = 0; off = 1'b0;
    m_data = '0; m_point = '0; m_sign = 1'b0;
    e_data = '0; e_point = '0; e_sign = 1'b0; e_seg_en = 1'b0;
    e_src = 2'd0; e_busy = 1'b0; e_ovf = 1'b0;
  endtask

  task automatic model_edge();
    int prev;
    logic [19:0] mag;
    cyc++;
    prev = mode;
    if (msg_req) begin
      mode = 2; left = HOLD_CLK;
      m_data = msg_data; m_point = msg_point; m_sign = msg_sign;
    end else if (mode == 2) begin
      left--;
      if (left == 0) mode = edit_active ? 1 : 0;
    end else begin
      mode = edit_active ? 1 : 0;
    end
    if (mode == 1 && prev != 1) begin
      bcnt = 0; off = 1'b0;
    end else if (cyc % TICK_CLK == 0) begin
      bcnt++;
      if (bcnt == BLINK_TICKS) begin bcnt = 0; off = !off; end
    end
    case (mode)
      1:       begin mag = edit_data; e_point = edit_point; e_sign = edit_sign; end
      2:       begin mag = m_data;    e_point = m_point;    e_sign = m_sign;    end
      default: begin mag = live_data; e_point = live_point; e_sign = live_sign; end
    endcase
    e_ovf    = (mag > DMAX);
    e_data   = e_ovf ? DMAX : mag;
    e_seg_en = !disp_off && !(mode == 1 && edit_blink && off);
    e_src    = 2'(mode);
    e_busy   = (mode == 2);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".data"},     32'(data),     32'(e_data));
    chk({tag, ".point"},    32'(point),    32'(e_point));
    chk({tag, ".sign"},     32'(sign),     32'(e_sign));
    chk({tag, ".seg_en"},   32'(seg_en),   32'(e_seg_en));
    chk({tag, ".src"},      32'(src),      32'(e_src));
    chk({tag, ".msg_busy"}, 32'(msg_busy), 32'(e_busy));
    chk({tag, ".ovf"},      32'(ovf),      32'(e_ovf));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs(tag);
  endtask

  initial begin
    int n;
    rstn = 1'b1;
    live_data = 20'd123456; live_point = 6'b000100; live_sign = 1'b0;
    edit_active = 1'b0; edit_data = '0; edit_point = '0; edit_sign = 1'b0; edit_blink = 1'b0;
    msg_req = 1'b0; msg_data = '0; msg_point = '0; msg_sign = 1'b0; disp_off = 1'b0;
    #2 rstn = 1'b0;
    #1 model_reset();
    check_outputs("reset");

    @(negedge clk) rstn = 1'b1;
    step("rel1");
    step("rel2");
    chk("rel_data", 32'(data), 32'd123456);
    chk("rel_point", 32'(point), 32'b000100);
    chk("rel_seg_en", 32'(seg_en), 32'd1);

    // Single message during live.
    msg_data = 20'd777; msg_point = 6'b000010; msg_sign = 1'b1; msg_req = 1'b1;
    step("msg_acc");
    msg_req = 1'b0; msg_data = 20'd31337;
    chk("msg_data", 32'(data), 32'd777);
    chk("msg_src", 32'(src), 32'd2);
    repeat (HOLD_CLK - 1) step("msg_hold");
    chk("msg_busy_last", 32'(msg_busy), 32'd1);
    step("msg_exp");
    chk("msg_busy_done", 32'(msg_busy), 32'd0);
    chk("msg_back_live", 32'(data), 32'd123456);

    // Edit with blink: measure full off and on runs.
    edit_active = 1'b1; edit_blink = 1'b1; edit_data = 20'd42; edit_point = 6'b100000;
    step("edit_ent");
    chk("edit_src", 32'(src), 32'd1);
    n = 0;
    while (seg_en !== 1'b0 && n < 60) begin step("blink_wait"); n++; end
    chk("blink_found_off", 32'(seg_en), 32'd0);
    n = 0;
    while (seg_en === 1'b0 && n < 60) begin step("blink_off"); n++; end
    chk("blink_off_len", 32'(n), 32'd20);
    n = 0;
    while (seg_en === 1'b1 && n < 60) begin step("blink_on"); n++; end
    chk("blink_on_len", 32'(n), 32'd20);
    edit_active = 1'b0;
    step("edit_exit");
    chk("edit_exit_src", 32'(src), 32'd0);
    chk("edit_exit_seg", 32'(seg_en), 32'd1);

    // Retrigger: newest message wins and hold restarts.
    msg_data = 20'd5; msg_req = 1'b1;
    step("rt_a");
    msg_req = 1'b0;
    repeat (19) step("rt_wait");
    msg_data = 20'd9; msg_req = 1'b1;
    step("rt_b");
    msg_req = 1'b0;
    chk("rt_data", 32'(data), 32'd9);
    repeat (HOLD_CLK - 1) step("rt_hold");
    chk("rt_busy_last", 32'(msg_busy), 32'd1);
    step("rt_exp");
    chk("rt_busy_done", 32'(msg_busy), 32'd0);

    // Request on the exact expiry edge.
    msg_data = 20'd3; msg_req = 1'b1;
    step("co_a");
    msg_req = 1'b0;
    repeat (HOLD_CLK - 1) step("co_hold");
    msg_data = 20'd11; msg_req = 1'b1;
    step("co_b");
    msg_req = 1'b0;
    chk("co_busy", 32'(msg_busy), 32'd1);
    chk("co_data", 32'(data), 32'd11);
    repeat (HOLD_CLK) step("co_hold2");
    chk("co_busy_done", 32'(msg_busy), 32'd0);

    // Saturation boundaries.
    live_data = 20'hFFFFF;    step("sat_max");
    chk("sat_data", 32'(data), 32'd999999);
    live_data = 20'd999999;   step("sat_eq");
    chk("sat_eq_ovf", 32'(ovf), 32'd0);
    live_data = 20'd1000000;  step("sat_over");
    chk("sat_over_ovf", 32'(ovf), 32'd1);

    // Blanking during a message does not alter hold timing.
    msg_data = 20'd64; msg_req = 1'b1;
    step("off_a");
    msg_req = 1'b0; disp_off = 1'b1;
    repeat (HOLD_CLK - 1) step("off_hold");
    chk("off_seg_en", 32'(seg_en), 32'd0);
    step("off_exp");
    chk("off_busy_done", 32'(msg_busy), 32'd0);
    disp_off = 1'b0;

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      live_data  = ($urandom_range(0, 1) == 0) ? 20'($urandom_range(0, 999999)) : 20'($urandom);
      live_point = 6'($urandom); live_sign = 1'($urandom);
      edit_data  = 20'($urandom); edit_point = 6'($urandom); edit_sign = 1'($urandom);
      msg_data   = 20'($urandom); msg_point = 6'($urandom); msg_sign = 1'($urandom);
      if ($urandom_range(0, 29) == 0) edit_active = !edit_active;
      if ($urandom_range(0, 49) == 0) edit_blink = !edit_blink;
      if ($urandom_range(0, 59) == 0) disp_off = !disp_off;
      msg_req = ($urandom_range(0, 39) == 0);
      step("rand");
    end
    msg_req = 1'b0; disp_off = 1'b0;

    // Asynchronous reset in the middle of a hold.
    edit_active = 1'b1; msg_data = 20'd100; msg_req = 1'b1;
    step("ar_msg");
    msg_req = 1'b0;
    repeat (10) step("ar_hold");
    #2 rstn = 1'b0;
    #1 model_reset();
    check_outputs("ar_async");
    @(negedge clk) rstn = 1'b1;
    step("ar_rel");
    chk("ar_src", 32'(src), 32'd1);
    chk("ar_busy", 32'(msg_busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seg_disp_arbiter.md
Name: seg_disp_arbiter

Overview:
Scheduler that shares the single 6-digit multiplexed seven-segment driver between three display sources: live measurement, setting edit, and timed event message. It selects one source by fixed priority and latches a message for a programmable hold time. It generates blink and blank control and saturates values that exceed 6 digits. Its outputs drive the driver's data/point/sign/seg_en inputs directly.

Parameters:
TICK_MAX, 16'd49_999, 1 ms prescaler terminal count (clk 50 MHz); 1 tick = TICK_MAX+1 clk
HOLD_MS, 16'd2000, message display duration in ticks
BLINK_MS, 10'd250, half-period of edit blink in ticks
DISP_MAX, 20'd999_999, largest displayable magnitude

Ports:
clk  in  1  system clock, 50 MHz
rstn  in  1  reset; asynchronous assert, active-low
live_data  in  20  ch0 magnitude (always valid, background)
live_point  in  6  ch0 decimal points, active-high
live_sign  in  1  ch0 negative
edit_active  in  1  ch1 level request: setting edit in progress
edit_data  in  20  ch1 magnitude
edit_point  in  6  ch1 decimal points
edit_sign  in  1  ch1 negative
edit_blink  in  1  ch1 blink enable
msg_req  in  1  ch2 single-cycle request pulse
msg_data  in  20  ch2 magnitude, sampled on msg_req
msg_point  in  6  ch2 points, sampled on msg_req
msg_sign  in  1  ch2 sign, sampled on msg_req
disp_off  in  1  global blank, level
data  out  20  to driver: value to show
point  out  6  to driver: decimal points
sign  out  1  to driver: minus sign
seg_en  out  1  to driver: display enable
src  out  2  current source: 0 live, 1 edit, 2 msg
msg_busy  out  1  message hold in progress
ovf  out  1  displayed value was saturated

Behaviour:
- All outputs registered. Reset values: data 0, point 0, sign 0, seg_en 0, src 0, msg_busy 0, ovf 0. Reset mid-hold or mid-blink aborts immediately. Internal state returns to S_LIVE with all counters 0.
- FSM states: S_LIVE, S_EDIT, S_MSG. Priority is msg > edit > live.
- S_LIVE -> S_MSG on msg_req. Otherwise S_LIVE -> S_EDIT on edit_active.
- S_EDIT -> S_MSG on msg_req. Otherwise S_EDIT -> S_LIVE on !edit_active.
- S_MSG -> S_EDIT/S_LIVE on hold expiry, chosen by edit_active at that cycle.
- msg_req in S_MSG re-latches the new message and restarts the hold (retrigger). The newest message wins.
- Message latch: on msg_req, msg_data/point/sign are captured into a holding register. The message inputs are ignored at all other times.
- Hold timing: a dedicated prescaler and hold counter are cleared on msg_req acceptance. Expiry occurs exactly HOLD_MS*(TICK_MAX+1) clk after the accepting edge. msg_busy=1 for exactly that many cycles.
- Blink: a free-running 1 ms tick drives a phase counter 0..BLINK_MS-1. The phase bit toggles at each wrap. On entry to S_EDIT the phase is forced to "on" and the counter cleared.
- seg_en = !disp_off && !(state==S_EDIT && edit_blink && phase_off).
- disp_off blanks only. Arbitration and hold timing continue unchanged.
- Saturation: if the selected magnitude > DISP_MAX, data = DISP_MAX and ovf=1; else data = input and ovf=0. Unsigned 20-bit compare.
- point and sign pass through unmodified from the selected source.
- Latency: a source change or input change appears on the outputs 1 clk after the FSM state/inputs settle. A msg_req at edge N shows msg data at edge N+1.
- Simultaneous msg_req and hold expiry in the same cycle: the request wins, re-latch and restart.
- Simultaneous edit_active fall and msg_req: go to S_MSG.
- Live and edit data are not latched; they pass through each cycle.

Decomposition:
- Shared package (seg_pkg): state encoding (S_LIVE=2'd0, S_EDIT=2'd1, S_MSG=2'd2), src codes, DISP_MAX, default TICK_MAX.
- One sub-module, ms_tick_gen: prescaler with sync clear, emits 1-clk tick at TICK_MAX. Two instances are used: a free-running one for blink, and one cleared on message acceptance for hold.

Test Plan:
(Bench parameters: TICK_MAX=9, HOLD_MS=3, BLINK_MS=2.)
- Reset release with live_data=123456, point=6'b000100 -> after 2 clk: data=123456, point=000100, src=0, seg_en=1, ovf=0.
- msg_req pulse with msg_data=777 during live -> next clk data=777, src=2, msg_busy=1 for exactly 30 clk, then data=live_data, src=0.
- edit_active=1, edit_blink=1, edit_data=42 -> src=1; seg_en is 1 for 20 clk, 0 for 20 clk, repeating. Drop edit_active -> src=0, seg_en=1 next clk.
- msg_req (data=5) then second msg_req (data=9) 20 clk later -> data=9 and busy extends to 30 clk after the second pulse. msg_req coincident with the expiry cycle -> busy stays 1.
- live_data=20'hFFFFF -> data=999999, ovf=1; live_data=999999 -> ovf=0. disp_off=1 during a message -> seg_en=0, expiry timing unchanged.
- Assert rstn=0 mid-hold with edit_active=1 -> all outputs return to reset values asynchronously. After release: src=1, msg_busy=0.
